// File: rtl/pipe_tag_pkg.sv
// Shared types for the destination-tag pipeline.
// Tag bundle carried through the EX, MEM and WB stage registers.
package pipe_tag_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '0;

endpackage

// File: rtl/tag_stage_reg.sv
// One stage tag register: async reset, hold, bubble and load.
// Ports: clk, rst_n, hold, bubble, d (incoming tag), q (stage tag).
module tag_stage_reg
  import pipe_tag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       bubble,
  input  stage_tag_t d,
  output stage_tag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE_TAG;
    end else if (!hold) begin
      if (bubble) begin
        q <= BUBBLE_TAG;
      end else begin
        q.rd        <= d.rd;
        // x0 is never a forwarding source
        q.reg_write <= d.reg_write & (d.rd != '0);
        q.mem_read  <= d.mem_read;
      end
    end
  end

endmodule

// File: rtl/rd_tag_pipeline.sv
// Carries rd tags ID->EX->MEM->WB, detects load-use, counts stalls.
// Ports: ID tag/sources, flush_ex, mem_wait in; stage tags, stall_id, stall_count out.
module rd_tag_pipeline
  import pipe_tag_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rd_id,
  input  logic             register_write_id,
  input  logic             mem_read_id,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             flush_ex,
  input  logic             mem_wait,
  output logic [REG_W-1:0] rd_ex,
  output logic             register_write_ex,
  output logic             mem_read_ex,
  output logic [REG_W-1:0] rd_mem,
  output logic             register_write_mem,
  output logic [REG_W-1:0] rd_wb,
  output logic             register_write_wb,
  output logic             stall_id,
  output logic [CNT_W-1:0] stall_count
);

  stage_tag_t id_t, ex_t, mem_t, wb_t;
  logic       load_use;

  assign id_t.rd        = rd_id;
  assign id_t.reg_write = register_write_id;
  assign id_t.mem_read  = mem_read_id;

  assign load_use = ex_t.mem_read
                  & (ex_t.rd != '0)
                  & ((ex_t.rd == rs1_id)
                   | (ex_t.rd == rs2_id));

  assign stall_id = mem_wait | load_use;

  // flush and load-use both turn EX into a bubble;
  // mem_wait freezes everything and overrides both
  tag_stage_reg u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (mem_wait),
    .bubble (flush_ex | load_use),
    .d      (id_t),
    .q      (ex_t)
  );

  tag_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (mem_wait),
    .bubble (1'b0),
    .d      (ex_t),
    .q      (mem_t)
  );

  tag_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (mem_wait),
    .bubble (1'b0),
    .d      (mem_t),
    .q      (wb_t)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_id && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign rd_ex              = ex_t.rd;
  assign register_write_ex  = ex_t.reg_write;
  assign mem_read_ex        = ex_t.mem_read;
  assign rd_mem             = mem_t.rd;
  assign register_write_mem = mem_t.reg_write;
  assign rd_wb              = wb_t.rd;
  assign register_write_wb  = wb_t.reg_write;

endmodule

// File: tb/tb_rd_tag_pipeline.sv
// Directed bench for rd_tag_pipeline.
// Second instance with CNT_W=4 exercises counter saturation.
module tb_rd_tag_pipeline;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rd_id, rs1_id, rs2_id;
  logic       register_write_id, mem_read_id;
  logic       flush_ex, mem_wait, sat_wait;

  logic [4:0]  rd_ex, rd_mem, rd_wb;
  logic        register_write_ex, mem_read_ex;
  logic        register_write_mem, register_write_wb;
  logic        stall_id;
  logic [31:0] stall_count;

  logic [4:0] s_rd_ex, s_rd_mem, s_rd_wb;
  logic       s_rw_ex, s_mr_ex, s_rw_mem, s_rw_wb, s_stall;
  logic [3:0] s_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rd_tag_pipeline dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rd_id              (rd_id),
    .register_write_id  (register_write_id),
    .mem_read_id        (mem_read_id),
    .rs1_id             (rs1_id),
    .rs2_id             (rs2_id),
    .flush_ex           (flush_ex),
    .mem_wait           (mem_wait),
    .rd_ex              (rd_ex),
    .register_write_ex  (register_write_ex),
    .mem_read_ex        (mem_read_ex),
    .rd_mem             (rd_mem),
    .register_write_mem (register_write_mem),
    .rd_wb              (rd_wb),
    .register_write_wb  (register_write_wb),
    .stall_id           (stall_id),
    .stall_count        (stall_count)
  );

  rd_tag_pipeline #(.CNT_W(4)) sat (
    .clk                (clk),
    .rst_n              (rst_n),
    .rd_id              (5'd0),
    .register_write_id  (1'b0),
    .mem_read_id        (1'b0),
    .rs1_id             (5'd0),
    .rs2_id             (5'd0),
    .flush_ex           (1'b0),
    .mem_wait           (sat_wait),
    .rd_ex              (s_rd_ex),
    .register_write_ex  (s_rw_ex),
    .mem_read_ex        (s_mr_ex),
    .rd_mem             (s_rd_mem),
    .register_write_mem (s_rw_mem),
    .rd_wb              (s_rd_wb),
    .register_write_wb  (s_rw_wb),
    .stall_id           (s_stall),
    .stall_count        (s_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [4:0] rd,
                    input logic w,
                    input logic mr);
    rd_id = rd;
    register_write_id = w;
    mem_read_id = mr;
  endtask

  task automatic tags(input string tag,
                      input logic [4:0] e,
                      input logic [4:0] m,
                      input logic [4:0] w);
    chk({tag, "_ex"}, 32'(rd_ex), 32'(e));
    chk({tag, "_mem"}, 32'(rd_mem), 32'(m));
    chk({tag, "_wb"}, 32'(rd_wb), 32'(w));
  endtask

  initial begin
    rst_n = 1'b0;
    id(5'd0, 1'b0, 1'b0);
    rs1_id = 5'd0;
    rs2_id = 5'd0;
    flush_ex = 1'b0;
    mem_wait = 1'b0;
    sat_wait = 1'b0;
    #1;
    tags("rst", 5'd0, 5'd0, 5'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_cnt", stall_count, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // latency 1/2/3
    id(5'd5, 1'b1, 1'b0);
    step();
    chk("lat_ex", 32'(rd_ex), 32'd5);
    chk("lat_rw_ex", 32'(register_write_ex), 32'd1);
    id(5'd0, 1'b0, 1'b0);
    step();
    chk("lat_mem", 32'(rd_mem), 32'd5);
    chk("lat_ex_clr", 32'(rd_ex), 32'd0);
    step();
    chk("lat_wb", 32'(rd_wb), 32'd5);
    chk("lat_rw_wb", 32'(register_write_wb), 32'd1);

    // x0 never forwards
    id(5'd0, 1'b1, 1'b0);
    step();
    chk("x0_rw_ex", 32'(register_write_ex), 32'd0);
    id(5'd0, 1'b0, 1'b0);
    step();
    chk("x0_rw_mem", 32'(register_write_mem), 32'd0);
    step();
    chk("x0_rw_wb", 32'(register_write_wb), 32'd0);

    // load-use on rs2
    id(5'd7, 1'b1, 1'b1);
    step();
    chk("lu_ex", 32'(rd_ex), 32'd7);
    chk("lu_mr_ex", 32'(mem_read_ex), 32'd1);
    id(5'd8, 1'b1, 1'b0);
    rs1_id = 5'd1;
    rs2_id = 5'd7;
    #1;
    chk("lu_stall", 32'(stall_id), 32'd1);
    step();
    tags("lu_bub", 5'd0, 5'd7, 5'd0);
    chk("lu_stall_off", 32'(stall_id), 32'd0);
    chk("lu_cnt", stall_count, 32'd1);
    step();
    tags("lu_re", 5'd8, 5'd0, 5'd7);

    // no false hazard
    rs1_id = 5'd0;
    rs2_id = 5'd0;
    id(5'd0, 1'b0, 1'b1);
    step();
    chk("nf_mr", 32'(mem_read_ex), 32'd1);
    id(5'd7, 1'b1, 1'b0);
    #1;
    chk("nf_x0_load", 32'(stall_id), 32'd0);
    step();
    rs1_id = 5'd7;
    #1;
    chk("nf_nonload", 32'(stall_id), 32'd0);
    rs1_id = 5'd0;

    // mem_wait freeze with 3/4/5
    id(5'd5, 1'b1, 1'b0);
    step();
    id(5'd4, 1'b1, 1'b0);
    step();
    id(5'd3, 1'b1, 1'b0);
    step();
    tags("mw_pre", 5'd3, 5'd4, 5'd5);
    id(5'd10, 1'b1, 1'b0);
    mem_wait = 1'b1;
    #1;
    chk("mw_stall", 32'(stall_id), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      tags("mw_hold", 5'd3, 5'd4, 5'd5);
    end
    chk("mw_cnt", stall_count, 32'd4);
    mem_wait = 1'b0;
    step();
    tags("mw_rel", 5'd10, 5'd3, 5'd4);
    chk("mw_cnt2", stall_count, 32'd4);

    // flush with load-use active
    id(5'd6, 1'b1, 1'b1);
    step();
    id(5'd9, 1'b1, 1'b0);
    rs1_id = 5'd6;
    flush_ex = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_id), 32'd1);
    step();
    tags("fl", 5'd0, 5'd6, 5'd10);
    chk("fl_rw_ex", 32'(register_write_ex), 32'd0);
    chk("fl_cnt", stall_count, 32'd5);
    flush_ex = 1'b0;
    rs1_id = 5'd0;

    // mid-stream reset
    id(5'd2, 1'b1, 1'b0);
    step();
    chk("mr_pre", 32'(rd_ex), 32'd2);
    rst_n = 1'b0;
    #1;
    tags("mr", 5'd0, 5'd0, 5'd0);
    chk("mr_rw", 32'(register_write_ex), 32'd0);
    chk("mr_cnt", stall_count, 32'd0);
    step();
    rst_n = 1'b1;

    // saturation on the 4-bit instance
    sat_wait = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("sat_full", 32'(s_count), 32'hF);
    step();
    step();
    chk("sat_hold", 32'(s_count), 32'hF);
    sat_wait = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
